range_union_counter: RTL and testbench
======================================

// Module: range_union_counter
// PURPOSE
//   Downstream of the input decoder: pairs the decoded number stream into inclusive
//   (lo,hi) ranges, buffers them, and on end_of_file merges overlapping/adjacent ranges
//   in place. Then sums the sizes of the merged ranges and reports the number of
//   distinct IDs covered. Result feeds the top-level answer/UART output stage.
// PARAMETERS
//   RANGE_WIDTH  64   width of lo/hi values; must match the decoder's RANGE_WIDTH
//   MAX_RANGES   256  range buffer depth (register array)
//   COUNT_WIDTH  64   width of the result accumulator
// PORTS
//   clk            in   1            clock
//   rst            in   1            async active-high reset
//   range_valid    in   1            one-cycle strobe from decoder: number on range_data
//   range_data     in   RANGE_WIDTH  decoded number; alternates lo, hi, lo, hi, ...
//   end_of_file    in   1            held high once the range section has ended
//   busy           out  1            high from end_of_file detection until result_valid
//   result_valid   out  1            one-cycle pulse when result_data is final
//   result_data    out  COUNT_WIDTH  total distinct IDs covered; held after pulse
//   overflow       out  1            sticky: a pair arrived with buffer full (pair dropped)
//   pair_error     out  1            sticky: lo>hi pair dropped, or dangling lo at EOF
// BEHAVIOUR
//   Reset (async assert): state=COLLECT, all entry valid bits 0, count 0, half-pair
//     flag 0; busy/result_valid/overflow/pair_error 0, result_data 0.
//   COLLECT: range_valid with half-pair flag 0 -> latch lo, set flag. With flag 1 ->
//     form (lo,hi), clear flag. Pair written at index count, valid=1, count++, if
//     count<MAX_RANGES and lo<=hi. lo>hi -> dropped, pair_error=1. count==MAX_RANGES ->
//     dropped, overflow=1.
//   end_of_file high in COLLECT -> next state SCAN, busy=1. A range_valid in the same
//     cycle is processed first. Half-pair flag still set -> pair_error=1, lo discarded.
//   SCAN: pointers i=0, j=1, pass-changed flag c=0. One (i,j) pair per cycle.
//     If valid[i] && valid[j] && lo[j]<=hi[i]+1 && lo[i]<=hi[j]+1:
//       entry i <= (min lo, max hi), valid[j] <= 0, c <= 1.
//     Compare widens to RANGE_WIDTH+1 bits so hi+1 never wraps.
//     j increments; when j==count-1, i++ and j=i+1.
//     Pass ends at i==count-1: if c, restart pass (i=0, j=1, c=0); else go to SUM.
//     count<=1 -> SUM directly. Repeated passes guarantee a fixed point.
//   SUM: k=0..count-1, one entry per cycle; if valid[k], acc += hi-lo+1 (COUNT_WIDTH,
//     modular). Then go to DONE.
//   DONE: result_data=acc, result_valid high for exactly 1 cycle on entry, busy=0.
//     Stays in DONE, ignoring all inputs, until reset.
//   Reset mid-SCAN/SUM aborts the run: buffer is cleared and no result pulse occurs.
//   Latency: EOF-to-result <= passes*count*(count-1)/2 + count + 2 cycles.
// CONFIGURATION
//   MERGE_STATS_EN defined: adds output merge_count [15:0], reset 0. It increments on
//     every successful merge, saturates at 16'hFFFF, and is held after DONE.
//   MERGE_STATS_EN undefined: port and counter absent; all other behaviour is identical.
// STRUCTURE
//   Shared package (aoc_pkg): range_t struct {lo,hi}, state enum
//     {COLLECT,SCAN,SUM,DONE}, overlap/adjacent function taking the widened compare.
//   One natural sub-module: range_pairer (stream -> range_t strobe + pair_error for
//     lo>hi); the merge/sum FSM and buffer stay in this module.
// TESTING
//   1. Pairs 3-5, 10-14, 16-20, 12-18, then EOF -> result_data=14, one result_valid
//      pulse, no flags set.
//   2. Adjacent ranges 1-2, 3-4 -> 4. Nested 1-100, 5-6 -> 100. Single 7-7 -> 1.
//   3. Chained merge needing a second pass: 1-2, 10-11, 3-9 -> 11. With
//      MERGE_STATS_EN: merge_count=2.
//   4. Odd stream 1,5,9 then EOF -> result 5, pair_error=1. Pair 9-3 -> dropped,
//      pair_error=1.
//   5. MAX_RANGES=4, six disjoint pairs -> overflow=1, sum of the first four only.
//      lo=0, hi=2^RANGE_WIDTH-1 -> no wrap in the adjacency compare.
//   6. Assert rst during SCAN -> all outputs 0 immediately. A fresh input stream then
//      produces the correct result with no stale entries.

Source files
------------

// File: rtl/aoc_pkg.sv
// Shared types for the range union counter: stored range pair, FSM state and the
// overlap-or-adjacent test used while merging.
package aoc_pkg;

  localparam int RANGE_W = 64;

  typedef struct packed {
    logic [RANGE_W-1:0] lo;
    logic [RANGE_W-1:0] hi;
  } range_t;

  typedef enum logic [1:0] {COLLECT, SCAN, SUM, DONE} state_t;

  localparam logic [RANGE_W:0] ONE_WIDE = (RANGE_W + 1)'(1);

  // Operands carry one extra bit so hi+1 at the top of the value range cannot wrap.
  function automatic logic ranges_touch(input logic [RANGE_W:0] lo_a, input logic [RANGE_W:0] hi_a,
                                        input logic [RANGE_W:0] lo_b, input logic [RANGE_W:0] hi_b);
    return (lo_b <= hi_a + ONE_WIDE) && (lo_a <= hi_b + ONE_WIDE);
  endfunction

endpackage

// File: rtl/range_union_counter_pairer.sv
// Turns the alternating lo/hi number stream into one range strobe per completed pair,
// flagging pairs whose lo exceeds hi instead of emitting them.
module range_pairer
  import aoc_pkg::*;
#(
  parameter int RANGE_WIDTH = RANGE_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic [RANGE_WIDTH-1:0] in_data,
  output logic                   pair_valid,
  output logic                   pair_bad,
  output range_t                 pair,
  output logic                   half
);

  logic                   half_q, half_d;
  logic [RANGE_WIDTH-1:0] lo_q, lo_d;

  always_comb begin
    half_d     = half_q;
    lo_d       = lo_q;
    pair_valid = 1'b0;
    pair_bad   = 1'b0;
    pair.lo    = lo_q;
    pair.hi    = in_data;
    if (!en) begin
      half_d = 1'b0;
    end else if (in_valid) begin
      if (!half_q) begin
        lo_d   = in_data;
        half_d = 1'b1;
      end else begin
        half_d = 1'b0;
        if (lo_q <= in_data) pair_valid = 1'b1;
        else                 pair_bad   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) half_q <= 1'b0;
    else     half_q <= half_d;
  end

  always_ff @(posedge clk) begin
    lo_q <= lo_d;
  end

  assign half = half_q;

endmodule

// File: rtl/range_union_counter.sv
// Buffers decoded ranges, merges overlapping/adjacent ones in place after end_of_file,
// then sums the merged sizes. Optional merge statistics behind MERGE_STATS_EN.
module range_union_counter
  import aoc_pkg::*;
#(
  parameter int RANGE_WIDTH = RANGE_W,
  parameter int MAX_RANGES  = 256,
  parameter int COUNT_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   range_valid,
  input  logic [RANGE_WIDTH-1:0] range_data,
  input  logic                   end_of_file,
  output logic                   busy,
  output logic                   result_valid,
  output logic [COUNT_WIDTH-1:0] result_data,
  output logic                   overflow,
  output logic                   pair_error
`ifdef MERGE_STATS_EN
  ,
  output logic [15:0]            merge_count
`endif
);

  localparam int CW = $clog2(MAX_RANGES + 1);
  localparam int IW = (MAX_RANGES > 1) ? $clog2(MAX_RANGES) : 1;
  localparam logic [CW-1:0]          FULL  = CW'(MAX_RANGES);
  localparam logic [CW-1:0]          ONE   = CW'(1);
  localparam logic [COUNT_WIDTH-1:0] ONE_C = COUNT_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [CW-1:0]           count_q, count_d, i_q, i_d, j_q, j_d, k_q, k_d;
  logic                    chg_q, chg_d;
  logic [MAX_RANGES-1:0]   valid_q, valid_d;
  range_t                  buf_q [MAX_RANGES];
  range_t                  buf_d [MAX_RANGES];
  logic [COUNT_WIDTH-1:0]  acc_q, acc_d, res_q, res_d;
  logic                    busy_q, busy_d, rv_q, rv_d, ovf_q, ovf_d, perr_q, perr_d;

  logic   pair_valid, pair_bad, half;
  range_t pair;
  range_t ent_i, ent_j, ent_k;
  logic   touch;
  logic [CW-1:0] last_idx;

  range_pairer #(.RANGE_WIDTH(RANGE_WIDTH)) u_pairer (
    .clk        (clk),
    .rst        (rst),
    .en         (state_q == COLLECT),
    .in_valid   (range_valid),
    .in_data    (range_data),
    .pair_valid (pair_valid),
    .pair_bad   (pair_bad),
    .pair       (pair),
    .half       (half)
  );

  assign ent_i    = buf_q[i_q[IW-1:0]];
  assign ent_j    = buf_q[j_q[IW-1:0]];
  assign ent_k    = buf_q[k_q[IW-1:0]];
  assign last_idx = count_q - ONE;
  assign touch    = valid_q[i_q[IW-1:0]] && valid_q[j_q[IW-1:0]] &&
                    ranges_touch({1'b0, ent_i.lo}, {1'b0, ent_i.hi}, {1'b0, ent_j.lo}, {1'b0, ent_j.hi});

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    chg_d   = chg_q;
    valid_d = valid_q;
    buf_d   = buf_q;
    acc_d   = acc_q;
    res_d   = res_q;
    busy_d  = busy_q;
    rv_d    = 1'b0;
    ovf_d   = ovf_q;
    perr_d  = perr_q;
    unique case (state_q)
      COLLECT: begin
        if (pair_valid || pair_bad) begin
          if (count_q == FULL) begin
            ovf_d = 1'b1;
          end else if (pair_valid) begin
            buf_d[count_q[IW-1:0]]   = pair;
            valid_d[count_q[IW-1:0]] = 1'b1;
            count_d                  = count_q + ONE;
          end
        end
        if (pair_bad) perr_d = 1'b1;
        if (end_of_file) begin
          // A lo arriving this same cycle still counts toward the dangling check.
          if (half ^ range_valid) perr_d = 1'b1;
          state_d = SCAN;
          busy_d  = 1'b1;
          i_d     = '0;
          j_d     = ONE;
          chg_d   = 1'b0;
        end
      end
      SCAN: begin
        if (count_q <= ONE) begin
          state_d = SUM;
          k_d     = '0;
          acc_d   = '0;
        end else begin
          if (touch) begin
            buf_d[i_q[IW-1:0]].lo  = (ent_j.lo < ent_i.lo) ? ent_j.lo : ent_i.lo;
            buf_d[i_q[IW-1:0]].hi  = (ent_j.hi > ent_i.hi) ? ent_j.hi : ent_i.hi;
            valid_d[j_q[IW-1:0]]   = 1'b0;
          end
          if (j_q == last_idx) begin
            if (i_q + ONE == last_idx) begin
              // End of pass: another pass only if something merged during this one.
              if (chg_q || touch) begin
                i_d   = '0;
                j_d   = ONE;
                chg_d = 1'b0;
              end else begin
                state_d = SUM;
                k_d     = '0;
                acc_d   = '0;
              end
            end else begin
              i_d   = i_q + ONE;
              j_d   = i_q + ONE + ONE;
              chg_d = chg_q || touch;
            end
          end else begin
            j_d   = j_q + ONE;
            chg_d = chg_q || touch;
          end
        end
      end
      SUM: begin
        if (count_q != '0 && valid_q[k_q[IW-1:0]])
          acc_d = acc_q + (COUNT_WIDTH'(ent_k.hi) - COUNT_WIDTH'(ent_k.lo) + ONE_C);
        if (count_q == '0 || k_q == last_idx) begin
          state_d = DONE;
          rv_d    = 1'b1;
          busy_d  = 1'b0;
          res_d   = acc_d;
        end else begin
          k_d = k_q + ONE;
        end
      end
      DONE: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      count_q <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      chg_q   <= 1'b0;
      valid_q <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
      ovf_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      chg_q   <= chg_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      rv_q    <= rv_d;
      ovf_q   <= ovf_d;
      perr_q  <= perr_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
    acc_q <= acc_d;
  end

`ifdef MERGE_STATS_EN
  logic        merge_inc;
  logic [15:0] mcnt_q, mcnt_d;

  assign merge_inc = (state_q == SCAN) && (count_q > ONE) && touch;

  always_comb begin
    mcnt_d = mcnt_q;
    if (merge_inc && mcnt_q != 16'hFFFF) mcnt_d = mcnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mcnt_q <= '0;
    else     mcnt_q <= mcnt_d;
  end

  assign merge_count = mcnt_q;
`endif

  assign busy         = busy_q;
  assign result_valid = rv_q;
  assign result_data  = res_q;
  assign overflow     = ovf_q;
  assign pair_error   = perr_q;

endmodule

// File: tb/tb_range_union_counter.sv
// Self-checking bench for range_union_counter: directed cases plus randomized streams
// compared against a sort-and-merge union model. Checks merge_count when MERGE_STATS_EN.
module tb_range_union_counter;

  localparam int RW   = 64;
  localparam int MAXR = 4;
  localparam int CWID = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            range_valid = 1'b0;
  logic [RW-1:0]   range_data = '0;
  logic            end_of_file = 1'b0;
  logic            busy, result_valid, overflow, pair_error;
  logic [CWID-1:0] result_data;
`ifdef MERGE_STATS_EN
  logic [15:0]     merge_count;
`endif

  always #5 clk = ~clk;

  range_union_counter #(.RANGE_WIDTH(RW), .MAX_RANGES(MAXR), .COUNT_WIDTH(CWID)) dut (
    .clk          (clk),
    .rst          (rst),
    .range_valid  (range_valid),
    .range_data   (range_data),
    .end_of_file  (end_of_file),
    .busy         (busy),
    .result_valid (result_valid),
    .result_data  (result_data),
    .overflow     (overflow),
    .pair_error   (pair_error)
`ifdef MERGE_STATS_EN
    ,
    .merge_count  (merge_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] stim_q[$];
  logic [63:0] exp_res;
  logic        exp_perr, exp_ovf;
  int          exp_merges;

  // Reference: keep accepted pairs, sort by lo, sweep to form the union, count merges.
  task automatic build_model();
    logic [63:0] lo_a[$];
    logic [63:0] hi_a[$];
    logic [63:0] lo, hi, t, cur_lo, cur_hi;
    int n, groups;
    n = stim_q.size();
    exp_perr = (n % 2) != 0;
    exp_ovf  = 1'b0;
    for (int p = 0; p + 1 < n; p += 2) begin
      lo = stim_q[p];
      hi = stim_q[p+1];
      if (lo > hi) exp_perr = 1'b1;
      if (lo_a.size() == MAXR) exp_ovf = 1'b1;
      else if (lo <= hi) begin
        lo_a.push_back(lo);
        hi_a.push_back(hi);
      end
    end
    for (int a = 0; a < lo_a.size(); a++)
      for (int b = 0; b + 1 < lo_a.size() - a; b++)
        if (lo_a[b] > lo_a[b+1]) begin
          t = lo_a[b]; lo_a[b] = lo_a[b+1]; lo_a[b+1] = t;
          t = hi_a[b]; hi_a[b] = hi_a[b+1]; hi_a[b+1] = t;
        end
    exp_res = '0;
    groups  = 0;
    if (lo_a.size() > 0) begin
      cur_lo = lo_a[0];
      cur_hi = hi_a[0];
      groups = 1;
      for (int m = 1; m < lo_a.size(); m++) begin
        if ({1'b0, lo_a[m]} <= {1'b0, cur_hi} + 65'd1) begin
          if (hi_a[m] > cur_hi) cur_hi = hi_a[m];
        end else begin
          exp_res = exp_res + (cur_hi - cur_lo + 64'd1);
          cur_lo  = lo_a[m];
          cur_hi  = hi_a[m];
          groups++;
        end
      end
      exp_res = exp_res + (cur_hi - cur_lo + 64'd1);
    end
    exp_merges = lo_a.size() - groups;
  endtask

  task automatic check_idle(input string name);
    check($sformatf("%s/busy0", name), 64'(busy), 64'd0);
    check($sformatf("%s/rv0", name), 64'(result_valid), 64'd0);
    check($sformatf("%s/rd0", name), result_data, 64'd0);
    check($sformatf("%s/ovf0", name), 64'(overflow), 64'd0);
    check($sformatf("%s/perr0", name), 64'(pair_error), 64'd0);
`ifdef MERGE_STATS_EN
    check($sformatf("%s/mc0", name), 64'(merge_count), 64'd0);
`endif
  endtask

  task automatic apply_reset(input string name);
    range_valid = 1'b0;
    end_of_file = 1'b0;
    rst = 1'b1;
    #1;
    check_idle($sformatf("%s/rst", name));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drive_stream(input bit eof_with_last, input bit gaps);
    int n;
    n = stim_q.size();
    for (int v = 0; v < n; v++) begin
      range_valid = 1'b1;
      range_data  = stim_q[v];
      if (v == n - 1 && eof_with_last) end_of_file = 1'b1;
      tick();
      range_valid = 1'b0;
      if (gaps && ($urandom_range(0, 1) == 1) && !end_of_file) tick();
    end
    if (!end_of_file) begin
      end_of_file = 1'b1;
      tick();
    end
  endtask

  task automatic run_case(input string name, input bit do_reset, input bit eof_with_last, input bit gaps);
    int cycles;
    build_model();
    if (do_reset) apply_reset(name);
    drive_stream(eof_with_last, gaps);
    check($sformatf("%s/busy", name), 64'(busy), 64'd1);
    cycles = 0;
    while (!result_valid && cycles < 3000) begin
      tick();
      cycles++;
    end
    check($sformatf("%s/timeout", name), 64'(result_valid), 64'd1);
    check($sformatf("%s/result", name), result_data, exp_res);
    check($sformatf("%s/perr", name), 64'(pair_error), 64'(exp_perr));
    check($sformatf("%s/ovf", name), 64'(overflow), 64'(exp_ovf));
    check($sformatf("%s/busy_done", name), 64'(busy), 64'd0);
`ifdef MERGE_STATS_EN
    check($sformatf("%s/merges", name), 64'(merge_count), 64'(exp_merges));
`endif
    range_valid = 1'b1;
    range_data  = 64'($urandom);
    tick();
    range_valid = 1'b0;
    check($sformatf("%s/pulse1", name), 64'(result_valid), 64'd0);
    check($sformatf("%s/held", name), result_data, exp_res);
  endtask

  logic [63:0] lo_r, hi_r;
  int np;

  initial begin
    stim_q = '{64'd3, 64'd5, 64'd10, 64'd14, 64'd16, 64'd20, 64'd12, 64'd18};
    run_case("basic", 1, 0, 0);
    stim_q = '{64'd1, 64'd2, 64'd3, 64'd4};
    run_case("adjacent", 1, 0, 0);
    stim_q = '{64'd1, 64'd100, 64'd5, 64'd6};
    run_case("nested", 1, 0, 1);
    stim_q = '{64'd7, 64'd7};
    run_case("single", 1, 1, 0);
    stim_q = '{64'd1, 64'd2, 64'd10, 64'd11, 64'd3, 64'd9};
    run_case("chain", 1, 0, 0);
    stim_q = '{64'd1, 64'd5, 64'd9};
    run_case("dangling", 1, 0, 0);
    stim_q = '{64'd9, 64'd3};
    run_case("reversed", 1, 0, 0);
    stim_q = '{64'd0, 64'd0, 64'd2, 64'd2, 64'd4, 64'd4, 64'd6, 64'd6, 64'd8, 64'd8, 64'd10, 64'd10};
    run_case("overflow", 1, 0, 0);
    stim_q = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
    run_case("fullspan", 1, 0, 0);
    stim_q = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0};
    run_case("nowrap", 1, 0, 0);
    stim_q = {};
    run_case("empty", 1, 0, 0);

    // Abort during SCAN, then a fresh stream without any further reset.
    stim_q = '{64'd1, 64'd2, 64'd10, 64'd11, 64'd20, 64'd21, 64'd30, 64'd31};
    apply_reset("abort");
    drive_stream(0, 0);
    check("abort/busy", 64'(busy), 64'd1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_idle("abort/mid");
    end_of_file = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    stim_q = '{64'd5, 64'd6};
    run_case("fresh", 0, 0, 0);

    for (int r = 0; r < 40; r++) begin
      stim_q = {};
      np = $urandom_range(0, 6);
      for (int p = 0; p < np; p++) begin
        lo_r = 64'($urandom_range(0, 40));
        hi_r = lo_r + 64'($urandom_range(0, 8));
        if ($urandom_range(0, 9) == 0) begin
          stim_q.push_back(hi_r + 64'd1);
          stim_q.push_back(lo_r);
        end else begin
          stim_q.push_back(lo_r);
          stim_q.push_back(hi_r);
        end
      end
      if ($urandom_range(0, 4) == 0) stim_q.push_back(64'($urandom_range(0, 40)));
      run_case($sformatf("rand%0d", r), 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
